gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
- Input-conditioning stage directly upstream of the SoC's PIO_IN port.
- Takes raw asynchronous board inputs (4 push-buttons, 10 slide switches) and synchronizes, debounces and polarity-normalizes each bit.
- Produces a packed 32-bit word for the PIO_IN export, plus per-bit one-cycle edge pulses and software-clearable sticky press flags.
- Runs in the 25 MHz PLL clock domain.

Parameters:
- WIDTH, 14: number of conditioned input bits; legal range 1..32.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before accepting a new level (10 ms at 25 MHz); must be >= 1.
- CNT_WIDTH, 18: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- ACTIVE_LOW_MASK, 14'h000F: bits set to 1 are active-low at the pin (KEY[3:0]) and are inverted to logical active-high.

Ports:
- clk  input  1  25 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- raw_in  input  WIDTH  raw pins: bit 0..3 = KEY[3:0], bit 4..13 = SW[9:0].
- clr_sticky  input  WIDTH  per-bit sticky clear, one-cycle strobe.
- clean_out  output  WIDTH  debounced, logical active-high levels.
- rise_pulse  output  WIDTH  one-cycle pulse on logical 0->1 of clean_out.
- fall_pulse  output  WIDTH  one-cycle pulse on logical 1->0 of clean_out.
- sticky  output  WIDTH  latched logical rise, held until cleared.
- gpio_word  output  32  {(32-WIDTH) zeros, clean_out}; feeds PIO_IN.

Behaviour:
- Per-bit pipeline:
  - raw_in goes through a 2-FF synchronizer (sync1, sync2).
  - The debounce counter works on sync2 against a stable register.
  - Logical level = stable XOR ACTIVE_LOW_MASK[i].
- Reset, asynchronous, while reset_n=0:
  - sync1, sync2 and stable load ACTIVE_LOW_MASK[i], the idle pin level.
  - Counters = 0.
  - Therefore clean_out=0, rise_pulse=0, fall_pulse=0, sticky=0, gpio_word=0.
- Debounce per bit, per clock:
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches stable; any return to the old level restarts the count from 0.
- Latency:
  - A raw transition held constant changes clean_out exactly 2+DEBOUNCE_CYCLES rising edges after it is first sampled into sync1.
  - With DEBOUNCE_CYCLES=1 this is 3 cycles.
- Edge pulses:
  - Registered. rise_pulse[i]=1 for exactly the one cycle after clean_out[i] goes 0->1; fall_pulse likewise for 1->0.
  - Never both high at once.
  - A minimum of DEBOUNCE_CYCLES cycles separates consecutive pulses on a bit.
- Sticky:
  - sticky[i] is set in the cycle rise_pulse[i] is asserted.
  - It is cleared on the edge where clr_sticky[i]=1.
  - Simultaneous set and clear: set wins, so sticky stays 1.
  - Clear with no set pending: sticky=0 on the next cycle.
- gpio_word mirrors clean_out combinationally; the upper bits are constant 0.
- Bits are fully independent; no cross-bit interaction.
- Reset mid-debounce: the count is discarded and the bit returns to idle. A pin still asserted after reset release re-debounces from 0 and produces a fresh rise_pulse.
- Counter saturation cannot occur: it is bounded by DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=14, default mask):
- Reset: hold reset_n=0 with raw_in=14'h000F -> clean_out=0, sticky=0, gpio_word=32'h0. Release -> outputs stay 0 for 20 cycles.
- Clean press: drive raw_in[0] 1->0 and hold -> clean_out[0]=1 exactly 6 edges later. rise_pulse[0] high 1 cycle, sticky[0]=1, gpio_word=32'h1.
- Glitch reject: pulse raw_in[5] high for 3 cycles then low -> clean_out[5] never changes and no pulses occur. A 4-cycle pulse held through sync -> clean_out[5]=1, then after release fall_pulse[5] fires once.
- Bounce: toggle raw_in[2] every 2 cycles for 20 cycles, then hold 0 -> exactly one rise_pulse[2], 6 edges after the final hold begins.
- Sticky clear race: assert clr_sticky[0] in the same cycle as rise_pulse[0] -> sticky[0] stays 1. Assert clr_sticky[0] alone one cycle later -> sticky[0]=0.
- Reset mid-debounce: hold raw_in[4]=1, assert reset_n=0 after 3 cycles, release -> clean_out[4] rises 6 edges after release with one rise_pulse.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronize, debounce and polarity-normalize board inputs for PIO_IN
// Ports:
//   clk        - 25 MHz system clock
//   reset_n    - asynchronous active-low reset
//   raw_in     - raw pins (bit 0..3 = KEY[3:0], bit 4..13 = SW[9:0])
//   clr_sticky - per-bit one-cycle strobe clearing sticky
//   clean_out  - debounced logical active-high levels
//   rise_pulse - one-cycle pulse after clean_out rises
//   fall_pulse - one-cycle pulse after clean_out falls
//   sticky     - latched rise, held until cleared
//   gpio_word  - clean_out zero-extended to 32 bits
module gpio_input_conditioner #(
  parameter int WIDTH = 14,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH = 18,
  parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = 14'h000F
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr_sticky,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] sticky,
  output logic [31:0]      gpio_word
);
  logic [WIDTH-1:0] sync1, sync2, stable, accept, level;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  // accept marks the edge where sync2 has differed from stable long enough
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++)
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
  end
  assign level = sync2 ^ ACTIVE_LOW_MASK;
  assign clean_out = stable ^ ACTIVE_LOW_MASK;
  assign gpio_word = 32'(clean_out);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= ACTIVE_LOW_MASK;
      sync2 <= ACTIVE_LOW_MASK;
      stable <= ACTIVE_LOW_MASK;
      rise_pulse <= '0;
      fall_pulse <= '0;
      sticky <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      stable <= (stable & ~accept) | (sync2 & accept);
      rise_pulse <= accept & level;
      fall_pulse <= accept & ~level;
      // set comes from the registered pulse and wins over a same-cycle clear
      sticky <= rise_pulse | (sticky & ~clr_sticky);
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= (sync2[i] == stable[i] || accept[i]) ? '0 : cnt[i] + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed self-checking bench for gpio_input_conditioner
module tb_gpio_input_conditioner;
  logic clk = 0;
  logic reset_n;
  logic [13:0] raw_in, clr_sticky, clean_out, rise_pulse, fall_pulse, sticky;
  logic [31:0] gpio_word;
  int errors = 0, checks = 0;
  int rc [14];
  int fc [14];
  logic [3:0] acc;

  gpio_input_conditioner #(
    .WIDTH(14), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW_MASK(14'h000F)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clr_sticky(clr_sticky),
    .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .sticky(sticky), .gpio_word(gpio_word)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
        rc[i] += int'(rise_pulse[i]);
        fc[i] += int'(fall_pulse[i]);
      end
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 14; i++) begin
      rc[i] = 0;
      fc[i] = 0;
    end
  endtask

  initial begin
    clr_counts();
    reset_n = 0;
    raw_in = 14'h000F;
    clr_sticky = '0;
    step(3);
    chk("rst_clean", 32'(clean_out), 32'h0);
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_word", gpio_word, 32'h0);
    reset_n = 1;
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      acc |= {|clean_out, |rise_pulse, |fall_pulse, |sticky};
    end
    chk("idle_20", 32'(acc), 32'h0);

    clr_counts();
    raw_in[0] = 1'b0;
    step(5);
    chk("press_early", 32'(clean_out[0]), 32'h0);
    step(1);
    chk("press_clean", 32'(clean_out[0]), 32'h1);
    chk("press_rise", 32'(rise_pulse[0]), 32'h1);
    chk("press_word", gpio_word, 32'h1);
    step(1);
    chk("press_sticky", 32'(sticky[0]), 32'h1);
    chk("press_rise_off", 32'(rise_pulse[0]), 32'h0);
    raw_in[0] = 1'b1;
    step(6);
    chk("release_fall", 32'(fall_pulse[0]), 32'h1);
    chk("release_clean", 32'(clean_out[0]), 32'h0);
    chk("release_rise_cnt", 32'(rc[0]), 32'h1);

    clr_counts();
    raw_in[5] = 1'b1;
    step(3);
    raw_in[5] = 1'b0;
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      acc |= {1'b0, clean_out[5], rise_pulse[5], fall_pulse[5]};
    end
    chk("glitch_reject", 32'(acc), 32'h0);
    raw_in[5] = 1'b1;
    step(4);
    raw_in[5] = 1'b0;
    step(2);
    chk("pulse4_clean", 32'(clean_out[5]), 32'h1);
    chk("pulse4_rise", 32'(rise_pulse[5]), 32'h1);
    step(3);
    chk("pulse4_hold", 32'(clean_out[5]), 32'h1);
    step(1);
    chk("pulse4_fall", 32'(fall_pulse[5]), 32'h1);
    step(2);
    chk("pulse4_fall_cnt", 32'(fc[5]), 32'h1);
    chk("pulse4_clean_off", 32'(clean_out[5]), 32'h0);

    clr_counts();
    for (int k = 0; k < 10; k++) begin
      raw_in[2] = k[0];
      step(2);
    end
    chk("bounce_quiet", 32'(rc[2] + fc[2]), 32'h0);
    raw_in[2] = 1'b0;
    step(5);
    chk("bounce_early", 32'(clean_out[2]), 32'h0);
    step(1);
    chk("bounce_rise", 32'(rise_pulse[2]), 32'h1);
    step(4);
    chk("bounce_rise_cnt", 32'(rc[2]), 32'h1);

    raw_in[3] = 1'b0;
    step(6);
    chk("race_rise", 32'(rise_pulse[3]), 32'h1);
    clr_sticky[3] = 1'b1;
    step(1);
    chk("race_set_wins", 32'(sticky[3]), 32'h1);
    step(1);
    chk("race_clear", 32'(sticky[3]), 32'h0);
    clr_sticky[3] = 1'b0;

    clr_counts();
    raw_in[4] = 1'b1;
    step(3);
    reset_n = 0;
    #1;
    chk("mid_rst_clean", 32'(clean_out), 32'h0);
    chk("mid_rst_sticky", 32'(sticky), 32'h0);
    step(2);
    reset_n = 1;
    step(5);
    chk("post_rst_early", 32'(clean_out[4]), 32'h0);
    step(1);
    chk("post_rst_clean", 32'(clean_out[4]), 32'h1);
    chk("post_rst_rise", 32'(rise_pulse[4]), 32'h1);
    chk("post_rst_word", gpio_word, 32'h1C);
    step(3);
    chk("post_rst_rise_cnt", 32'(rc[4]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
